// File: rtl/id_ex_issue_pkg.sv
// Shared decode constants for the ID/EX issue stage: ALU op codes, RV32I
// opcodes, operand select codes, immediate field widths and the EX-slot record.
package id_ex_issue_pkg;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  // RV32I major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // funct7 values accepted by the integer ops
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Immediate-format field widths
  localparam int IMM_I_W = 12;
  localparam int IMM_S_W = 12;
  localparam int IMM_B_W = 13;
  localparam int IMM_U_W = 20;
  localparam int SHAMT_W = 5;

  // Operand select codes
  localparam logic [1:0] SEL1_RS1  = 2'd0;
  localparam logic [1:0] SEL1_PC   = 2'd1;
  localparam logic [1:0] SEL1_ZERO = 2'd2;
  localparam logic [1:0] SEL2_RS2  = 2'd0;
  localparam logic [1:0] SEL2_IMM  = 2'd1;
  localparam logic [1:0] SEL2_ZERO = 2'd2;

  // Contents of the EX slot; all-zero is the bubble
  typedef struct packed {
    logic        valid;
    logic [3:0]  alu_op;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
  } issue_t;

  localparam issue_t BUBBLE = '0;

endpackage

// File: rtl/id_ex_issue_decode.sv
// Combinational RV32I decode for the issue stage: ALU op, operand selects,
// immediate, register indices and the unsupported-instruction flag.
module issue_decode
  import id_ex_issue_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  alu_op,
  output logic [1:0]  sel1,
  output logic [1:0]  sel2,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        writes_rd,
  output logic        illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_sh;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  // Only formats that write a register report a destination
  assign rd     = writes_rd ? instr[11:7] : 5'd0;

  assign imm_i  = {{(32-IMM_I_W){instr[31]}}, instr[31:20]};
  assign imm_s  = {{(32-IMM_S_W){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{(32-IMM_B_W){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:32-IMM_U_W], {(32-IMM_U_W){1'b0}}};
  // Shift-immediates carry only the shift amount, not the funct7 bits
  assign imm_sh = {{(32-SHAMT_W){1'b0}}, instr[24:20]};

  // Decode by major opcode; defaults describe an illegal/zero-operand ADD
  always_comb begin
    alu_op    = ALU_ADD;
    sel1      = SEL1_ZERO;
    sel2      = SEL2_ZERO;
    imm       = '0;
    writes_rd = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE || (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          alu_op    = {funct7[5], funct3};
          sel1      = SEL1_RS1;
          sel2      = SEL2_RS2;
          writes_rd = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        sel1      = SEL1_RS1;
        sel2      = SEL2_IMM;
        writes_rd = 1'b1;
        alu_op    = {1'b0, funct3};
        imm       = imm_i;
        if (funct3 == 3'b001) begin
          imm = imm_sh;
          if (funct7 != F7_BASE) begin
            illegal = 1'b1;
          end
        end else if (funct3 == 3'b101) begin
          imm = imm_sh;
          if (funct7 == F7_ALT) begin
            alu_op = ALU_SRA;
          end else if (funct7 != F7_BASE) begin
            illegal = 1'b1;
          end
        end
      end
      OPC_LUI: begin
        sel1 = SEL1_ZERO; sel2 = SEL2_IMM; imm = imm_u; writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        sel1 = SEL1_PC; sel2 = SEL2_IMM; imm = imm_u; writes_rd = 1'b1;
      end
      OPC_LOAD: begin
        sel1 = SEL1_RS1; sel2 = SEL2_IMM; imm = imm_i; writes_rd = 1'b1;
      end
      OPC_STORE: begin
        sel1 = SEL1_RS1; sel2 = SEL2_IMM; imm = imm_s;
      end
      OPC_JAL, OPC_JALR: begin
        sel1 = SEL1_PC; sel2 = SEL2_IMM; imm = 32'd4; writes_rd = 1'b1;
      end
      OPC_BRANCH: begin
        sel1 = SEL1_PC; sel2 = SEL2_IMM; imm = imm_b;
      end
      default: illegal = 1'b1;
    endcase
    // An unsupported instruction issues as a harmless zero-operand ADD
    if (illegal) begin
      alu_op    = ALU_ADD;
      sel1      = SEL1_ZERO;
      sel2      = SEL2_ZERO;
      imm       = '0;
      writes_rd = 1'b0;
    end
  end

endmodule

// File: rtl/id_ex_issue.sv
// ID/EX issue register: decodes the instruction in the decode slot, forwards
// operands from EX/MEM and MEM/WB, and registers the result into the EX slot.
module id_ex_issue
  import id_ex_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_write,
  input  logic [XLEN-1:0] ex_result,
  input  logic [4:0]      wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_result,
  input  logic            stall,
  input  logic            flush,
  output logic            out_valid,
  output logic [3:0]      out_alu_op,
  output logic [XLEN-1:0] out_data1,
  output logic [XLEN-1:0] out_data2,
  output logic [XLEN-1:0] out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_illegal
);

  logic [3:0]  dec_op;
  logic [1:0]  dec_sel1;
  logic [1:0]  dec_sel2;
  logic [31:0] dec_imm;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        dec_writes;
  logic        dec_illegal;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  issue_t      stage_next;
  issue_t      stage_reg;

  issue_decode u_decode (
    .instr     (in_instr),
    .alu_op    (dec_op),
    .sel1      (dec_sel1),
    .sel2      (dec_sel2),
    .imm       (dec_imm),
    .rs1       (dec_rs1),
    .rs2       (dec_rs2),
    .rd        (dec_rd),
    .writes_rd (dec_writes),
    .illegal   (dec_illegal)
  );

  // Youngest producer wins; x0 is hard-wired to zero whatever the bypass says
  function automatic logic [31:0] forward(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 5'd0)                         return 32'd0;
    else if (ex_reg_write && ex_rd == rs)   return ex_result;
    else if (wb_reg_write && wb_rd == rs)   return wb_result;
    else                                    return rf;
  endfunction

  // Forwarded operands and the would-be EX slot contents
  always_comb begin
    rs1_val = forward(dec_rs1, rs1_data);
    rs2_val = forward(dec_rs2, rs2_data);
    stage_next           = BUBBLE;
    stage_next.valid     = 1'b1;
    stage_next.alu_op    = dec_op;
    stage_next.rd        = dec_rd;
    stage_next.reg_write = dec_writes && (dec_rd != 5'd0);
    stage_next.illegal   = dec_illegal;
    stage_next.rs2       = dec_illegal ? 32'd0 : rs2_val;
    case (dec_sel1)
      SEL1_RS1: stage_next.data1 = rs1_val;
      SEL1_PC:  stage_next.data1 = in_pc;
      default:  stage_next.data1 = 32'd0;
    endcase
    case (dec_sel2)
      SEL2_RS2: stage_next.data2 = rs2_val;
      SEL2_IMM: stage_next.data2 = dec_imm;
      default:  stage_next.data2 = 32'd0;
    endcase
  end

  // EX slot register: flush beats stall, an empty decode slot loads a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_reg <= BUBBLE;
    end else if (flush) begin
      stage_reg <= BUBBLE;
    end else if (!stall) begin
      stage_reg <= in_valid ? stage_next : BUBBLE;
    end
  end

  assign out_valid     = stage_reg.valid;
  assign out_alu_op    = stage_reg.alu_op;
  assign out_data1     = stage_reg.data1;
  assign out_data2     = stage_reg.data2;
  assign out_rs2       = stage_reg.rs2;
  assign out_rd        = stage_reg.rd;
  assign out_reg_write = stage_reg.reg_write;
  assign out_illegal   = stage_reg.illegal;

endmodule
